// File: rtl/nibble_compare_sequencer.sv
// nibble_compare_sequencer: wide unsigned compare by walking one external 4-bit slice LSB-first.
// Optional CASCADE_IN_EN adds i_albi/i_agbi/i_aebi as the cascade seed latched on START.
module nibble_compare_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [4*NIBBLES-1:0]   i_a,
  input  logic [4*NIBBLES-1:0]   i_b,
`ifdef CASCADE_IN_EN
  input  logic                   i_albi,
  input  logic                   i_agbi,
  input  logic                   i_aebi,
`endif
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_alb,
  output logic                   o_agb,
  output logic                   o_aeb,
  output logic                   o_err,
  output logic [3:0]             o_sl_a,
  output logic [3:0]             o_sl_b,
  output logic                   o_sl_albi,
  output logic                   o_sl_agbi,
  output logic                   o_sl_aebi,
  input  logic                   i_sl_albo,
  input  logic                   i_sl_agbo,
  input  logic                   i_sl_aebo
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t                 r_state, w_next;
  logic [IW-1:0]          r_idx;
  logic [4*NIBBLES-1:0]   r_a, r_b;
  logic [2:0]             r_casc, r_res, w_slice, w_seed;
  logic                   r_err, w_accept, w_last, w_run;
`ifdef CASCADE_IN_EN
  assign w_seed = {i_albi, i_agbi, i_aebi};
`else
  assign w_seed = 3'b001;
`endif
  assign w_run    = r_state == S_RUN;
  assign w_accept = i_start && !w_run;
  assign w_last   = r_idx == IW'(NIBBLES - 1);
  assign w_slice  = {i_sl_albo, i_sl_agbo, i_sl_aebo};
  always_comb begin
    w_next = r_state;
    w_next = w_run ? (w_last ? S_DONE : S_RUN) : (i_start ? S_RUN : S_IDLE);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_casc <= 3'b001;
      r_res  <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_idx  <= '0;
      r_a    <= i_a;
      r_b    <= i_b;
      r_casc <= w_seed;
      r_res  <= '0;
      r_err  <= 1'b0;
    end else if (w_run) begin
      r_casc <= w_slice;
      r_idx  <= w_last ? r_idx : r_idx + IW'(1);
      r_err  <= r_err | !$onehot(w_slice);
      if (w_last) r_res <= w_slice;
    end
  end
  assign o_busy = w_run;
  assign o_done = r_state == S_DONE;
  assign {o_alb, o_agb, o_aeb} = r_res;
  assign o_err  = r_err;
  assign o_sl_a = r_a[4*r_idx +: 4];
  assign o_sl_b = r_b[4*r_idx +: 4];
  assign {o_sl_albi, o_sl_agbi, o_sl_aebi} = r_casc;
endmodule

// File: tb/tb_nibble_compare_sequencer.sv
// tb_nibble_compare_sequencer: directed checks with a behavioural 74x85-style slice model.
module tb_nibble_compare_sequencer;
  localparam int N = 4;
  logic clk = 0, rst_n = 0, start = 0;
  logic [4*N-1:0] a = '0, b = '0;
  logic busy, done, alb, agb, aeb, err;
  logic [3:0] sl_a, sl_b;
  logic sl_albi, sl_agbi, sl_aebi;
  logic [2:0] slice;
  logic inj = 0;
  int run_cnt = 0;
  int total = 0, bad = 0;
`ifdef CASCADE_IN_EN
  logic albi = 0, agbi = 0, aebi = 1;
`endif
  always #5 clk = ~clk;
  nibble_compare_sequencer #(.NIBBLES(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
`ifdef CASCADE_IN_EN
    .i_albi(albi), .i_agbi(agbi), .i_aebi(aebi),
`endif
    .o_busy(busy), .o_done(done), .o_alb(alb), .o_agb(agb), .o_aeb(aeb), .o_err(err),
    .o_sl_a(sl_a), .o_sl_b(sl_b),
    .o_sl_albi(sl_albi), .o_sl_agbi(sl_agbi), .o_sl_aebi(sl_aebi),
    .i_sl_albo(slice[2]), .i_sl_agbo(slice[1]), .i_sl_aebo(slice[0])
  );
  // position of the nibble being processed, counted from the bench's view of BUSY
  always @(posedge clk) run_cnt <= busy ? run_cnt + 1 : 0;
  always_comb begin
    slice = {sl_albi, sl_agbi, sl_aebi};
    if (inj && busy && run_cnt == 1) slice = 3'b110;
    else if (sl_a < sl_b)            slice = 3'b100;
    else if (sl_a > sl_b)            slice = 3'b010;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // single-cycle START, scramble A/B after acceptance, check BUSY window and results
  task automatic run(input string tag, input logic [4*N-1:0] ra, input logic [4*N-1:0] rb,
                     input logic [2:0] res, input logic e);
    a = ra; b = rb; start = 1;
    tick();
    start = 0; a = ~ra; b = ~rb;
    for (int i = 0; i < N; i++) begin
      chk({tag, "_busy"}, {busy, done}, 2'b10);
      tick();
    end
    chk({tag, "_done"}, {busy, done}, 2'b01);
    chk({tag, "_res"}, {alb, agb, aeb}, res);
    chk({tag, "_err"}, err, e);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_res_hold"}, {alb, agb, aeb}, res);
  endtask
  initial begin
    tick(2);
    chk("rst_outs", {busy, done, alb, agb, aeb, err}, 6'b0);
    chk("rst_casc", {sl_albi, sl_agbi, sl_aebi}, 3'b001);
    rst_n = 1;
    tick();
    chk("idle", {busy, done}, 2'b00);
    run("eq", 16'h1234, 16'h1234, 3'b001, 1'b0);
    run("gt_ms", 16'h8000, 16'h7FFF, 3'b010, 1'b0);
    run("lt", 16'h0001, 16'h0002, 3'b100, 1'b0);
    run("lt_ms", 16'h1FFF, 16'h2000, 3'b100, 1'b0);
    // START held high: back-to-back runs with no IDLE cycle
    a = 16'hFFFF; b = 16'hFFFF; start = 1;
    tick();
    for (int i = 0; i < N; i++) begin
      chk("b2b1_busy", {busy, done}, 2'b10);
      tick();
    end
    chk("b2b1_done", {busy, done}, 2'b01);
    chk("b2b1_res", {alb, agb, aeb}, 3'b001);
    a = 16'h0000;
    tick();
    start = 0;
    chk("b2b2_start", {busy, done}, 2'b10);
    tick(N - 1);
    chk("b2b2_last_busy", {busy, done}, 2'b10);
    tick();
    chk("b2b2_done", {busy, done}, 2'b01);
    chk("b2b2_res", {alb, agb, aeb}, 3'b100);
    tick();
    // reset in the second RUN cycle aborts at once
    a = 16'h4444; b = 16'h3333; start = 1;
    tick();
    start = 0;
    tick();
    chk("abort_pre", busy, 1'b1);
    rst_n = 0;
    #1;
    chk("abort_now", {busy, done, alb, agb, aeb, err}, 6'b0);
    tick();
    rst_n = 1;
    for (int i = 0; i < N + 2; i++) begin
      chk("abort_nodone", {busy, done}, 2'b00);
      tick();
    end
    // non-one-hot slice result on nibble 1 propagates verbatim and sets ERR
    inj = 1;
    run("inj", 16'h1234, 16'h1234, 3'b110, 1'b1);
    inj = 0;
    a = 16'h0F00; b = 16'h0E00; start = 1;
    tick();
    start = 0;
    chk("err_clr", err, 1'b0);
    tick(N);
    chk("err_clr_done", {done, err, alb, agb, aeb}, 5'b10010);
    tick();
`ifdef CASCADE_IN_EN
    albi = 0; agbi = 1; aebi = 0;
    run("seed", 16'h5A5A, 16'h5A5A, 3'b010, 1'b0);
    albi = 0; agbi = 0; aebi = 1;
`else
    run("seed", 16'h5A5A, 16'h5A5A, 3'b001, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
